// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - SHA-2 round constant tables, round counts and sequencer state encoding
package sha2_pkg;

    localparam int ROUNDS_256 = 64;
    localparam int ROUNDS_512 = 80;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [31:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] SHA512_K [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

endpackage

// File: rtl/sha2_k_table.sv
// rtl/sha2_k_table.sv - combinational SHA-2 round constant lookup, zero beyond the last round
module sha2_k_table
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [6:0]        addr,
    output logic [WORD_W-1:0] data
);

    generate
        if (WORD_W == 64) begin : g_512
            // SHA-384/512 table, 80 entries
            always_comb begin
                data = '0;
                if (addr < 7'(ROUNDS_512)) begin
                    data = SHA512_K[addr];
                end
            end
        end else begin : g_256
            // SHA-224/256 table, 64 entries
            always_comb begin
                data = '0;
                if (addr < 7'(ROUNDS_256)) begin
                    data = SHA256_K[addr[5:0]];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sha2_k_sequencer.sv
// rtl/sha2_k_sequencer.sv - streams SHA-2 round constants with round counter, last flag and done pulse
module sha2_k_sequencer
    import sha2_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int LOOKAHEAD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              k_ready,
    output logic              k_valid,
    output logic [WORD_W-1:0] k_data,
    output logic [6:0]        k_round,
    output logic              k_last,
    output logic [WORD_W-1:0] k_next,
    output logic              busy,
    output logic              done
);

    localparam int         ROUNDS     = (WORD_W == 64) ? ROUNDS_512 : ROUNDS_256;
    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

    state_t            state;
    logic [6:0]        load_addr;
    logic [6:0]        la_addr;
    logic [WORD_W-1:0] load_k;
    logic [WORD_W-1:0] la_k;

    // Constant to register on the next edge: K[0] when starting, K[round+1] when advancing
    always_comb begin
        load_addr = 7'd0;
        if (state == ST_RUN) begin
            load_addr = k_round + 7'd1;
        end
    end

    assign la_addr = k_round + 7'd1;

    sha2_k_table #(.WORD_W(WORD_W)) u_cur_table (
        .addr (load_addr),
        .data (load_k)
    );

    sha2_k_table #(.WORD_W(WORD_W)) u_la_table (
        .addr (la_addr),
        .data (la_k)
    );

    // Lookahead is only meaningful while a constant is presented and more rounds follow
    generate
        if (LOOKAHEAD != 0) begin : g_la
            assign k_next = (k_valid && !k_last) ? la_k : '0;
        end else begin : g_no_la
            assign k_next = '0;
        end
    endgenerate

    assign busy = (state == ST_RUN);

    // Sequencer FSM: abort overrides everything; k_data/k_round persist in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            k_valid <= 1'b0;
            k_data  <= '0;
            k_round <= 7'd0;
            k_last  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state   <= ST_IDLE;
                k_valid <= 1'b0;
                k_round <= 7'd0;
                k_last  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state   <= ST_RUN;
                            k_valid <= 1'b1;
                            k_round <= 7'd0;
                            k_data  <= load_k;
                            k_last  <= (LAST_ROUND == 7'd0);
                        end
                    end
                    ST_RUN: begin
                        if (k_ready) begin
                            if (k_last) begin
                                state   <= ST_IDLE;
                                k_valid <= 1'b0;
                                k_last  <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                k_round <= load_addr;
                                k_data  <= load_k;
                                k_last  <= (load_addr == LAST_ROUND);
                            end
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        k_valid <= 1'b0;
                        k_last  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha2_k_sequencer.sv
// tb/tb_sha2_k_sequencer.sv - scoreboard bench for sha2_k_sequencer, 32- and 64-bit variants
module tb_sha2_k_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        k_ready;

    logic        v32, l32, n32_busy, d32;
    logic [31:0] k32, nx32;
    logic [6:0]  r32;
    logic        v64, l64, n64_busy, d64;
    logic [63:0] k64, nx64;
    logic [6:0]  r64;

    sha2_k_sequencer #(.WORD_W(32), .LOOKAHEAD(1)) u32 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .k_ready(k_ready),
        .k_valid(v32), .k_data(k32), .k_round(r32), .k_last(l32),
        .k_next(nx32), .busy(n32_busy), .done(d32)
    );

    sha2_k_sequencer #(.WORD_W(64), .LOOKAHEAD(1)) u64 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .k_ready(k_ready),
        .k_valid(v64), .k_data(k64), .k_round(r64), .k_last(l64),
        .k_next(nx64), .busy(n64_busy), .done(d64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  round;
        logic        last;
        logic        known;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];

    int n_vec  = 0;
    int n_miss = 0;
    int n_xfer = 0;

    bit          sel;
    logic        m_valid, m_last, m_busy, m_done;
    logic [63:0] m_data, m_next;
    logic [6:0]  m_round;
    int          m_rounds;

    bit          pend_done;
    bit          have_prev;
    logic [6:0]  prev_round;
    logic [63:0] prev_next;
    bit          stall_pend;
    logic [6:0]  stall_round;
    logic [63:0] stall_data;

    always_comb begin
        if (sel) begin
            m_valid = v64; m_last = l64; m_busy = n64_busy; m_done = d64;
            m_data = k64; m_next = nx64; m_round = r64; m_rounds = 80;
        end else begin
            m_valid = v32; m_last = l32; m_busy = n32_busy; m_done = d32;
            m_data = {32'h0, k32}; m_next = {32'h0, nx32}; m_round = r32; m_rounds = 64;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Hand-copied reference constants from FIPS 180-4 at selected rounds
    function automatic bit spot_k(input bit w64, input int r, output logic [63:0] v);
        v = '0;
        spot_k = 1'b1;
        if (!w64) begin
            case (r)
                0:  v = 64'h428a2f98;
                5:  v = 64'h59f111f1;
                6:  v = 64'h923f82a4;
                17: v = 64'hefbe4786;
                40: v = 64'ha2bfe8a1;
                63: v = 64'hc67178f2;
                default: spot_k = 1'b0;
            endcase
        end else begin
            case (r)
                0:  v = 64'h428a2f98d728ae22;
                1:  v = 64'h7137449123ef65cd;
                40: v = 64'ha2bfe8a14cf10364;
                64: v = 64'hca273eceea26619c;
                79: v = 64'h6c44198c4a475817;
                default: spot_k = 1'b0;
            endcase
        end
    endfunction

    task automatic push_seq(input int rounds);
        exp_t e;
        logic [63:0] v;
        for (int i = 0; i < rounds; i++) begin
            e.round = 7'(i);
            e.last  = (i == rounds - 1);
            e.known = spot_k(sel, i, v);
            e.data  = v;
            exp_q.push_back(e);
        end
    endtask

    task automatic flush();
        exp_q.delete();
        pend_done  = 1'b0;
        have_prev  = 1'b0;
        stall_pend = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every transfer and checks the side flags each cycle
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            chk("done_pulse", {63'h0, m_done}, {63'h0, pend_done});
            pend_done = 1'b0;
            chk("busy_vs_valid", {63'h0, m_busy}, {63'h0, m_valid});
            if (m_valid) begin
                chk("k_last_flag", {63'h0, m_last}, {63'h0, (int'(m_round) == m_rounds - 1)});
                if (m_last) chk("k_next_at_last", m_next, 64'h0);
                if (stall_pend) begin
                    chk("stall_round", {57'h0, m_round}, {57'h0, stall_round});
                    chk("stall_data", m_data, stall_data);
                end
            end
            stall_pend  = m_valid && !k_ready;
            stall_round = m_round;
            stall_data  = m_data;
            if (m_valid && k_ready && !abort) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_transfer");
                end else begin
                    e = exp_q.pop_front();
                    chk("round_order", {57'h0, m_round}, {57'h0, e.round});
                    chk("last_at_xfer", {63'h0, m_last}, {63'h0, e.last});
                    if (e.known) chk("k_data_ref", m_data, e.data);
                    if (have_prev && m_round == prev_round + 7'd1)
                        chk("k_next_vs_data", m_data, prev_next);
                    if (e.last) pend_done = 1'b1;
                end
                have_prev  = !m_last;
                prev_round = m_round;
                prev_next  = m_next;
            end
        end
    end

    task automatic begin_seq(input int rounds);
        n_xfer = 0;
        push_seq(rounds);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_latency_valid", {63'h0, m_valid}, 64'h1);
        chk("start_round0", {57'h0, m_round}, 64'h0);
    endtask

    task automatic wait_round(input int r);
        int t = 0;
        while (!(m_valid && m_round == 7'(r))) begin
            @(posedge clk); #1;
            t++;
            if (t > 500) begin
                fail_now("wait_round_timeout");
                return;
            end
        end
    endtask

    task automatic wait_done(input bit bp);
        int t = 0;
        while (!m_done) begin
            k_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            t++;
            if (t > 1000) begin
                fail_now("wait_done_timeout");
                return;
            end
        end
        k_ready = 1'b1;
    endtask

    task automatic end_checks(input int rounds);
        chk("xfer_count", 64'(n_xfer), 64'(rounds));
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; k_ready = 1'b0; sel = 1'b0;
        flush();
        #2;
        chk("rst_valid32", {63'h0, v32}, 64'h0);
        chk("rst_data32", {32'h0, k32}, 64'h0);
        chk("rst_round32", {57'h0, r32}, 64'h0);
        chk("rst_last32", {63'h0, l32}, 64'h0);
        chk("rst_next32", {32'h0, nx32}, 64'h0);
        chk("rst_busy32", {63'h0, n32_busy}, 64'h0);
        chk("rst_done32", {63'h0, d32}, 64'h0);
        chk("rst_valid64", {63'h0, v64}, 64'h0);
        chk("rst_data64", k64, 64'h0);
        chk("rst_next64", nx64, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: full 32-bit sequence, no backpressure
        sel = 1'b0; k_ready = 1'b1;
        begin_seq(64);
        wait_done(1'b0);
        end_checks(64);
        @(posedge clk); #1;

        // 2: full 64-bit sequence
        do_reset();
        sel = 1'b1; k_ready = 1'b1;
        begin_seq(80);
        wait_done(1'b0);
        end_checks(80);
        @(posedge clk); #1;

        // 3: random backpressure on the 32-bit variant
        do_reset();
        sel = 1'b0;
        begin_seq(64);
        wait_done(1'b1);
        end_checks(64);
        @(posedge clk); #1;

        // 4: abort at round 17 together with start and k_ready, then restart
        do_reset();
        k_ready = 1'b1;
        begin_seq(64);
        wait_round(17);
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("abort_valid", {63'h0, m_valid}, 64'h0);
        chk("abort_round", {57'h0, m_round}, 64'h0);
        chk("abort_busy", {63'h0, m_busy}, 64'h0);
        flush();
        @(posedge clk); #1;
        chk("abort_no_done", {63'h0, m_done}, 64'h0);
        begin_seq(64);
        wait_done(1'b0);
        end_checks(64);
        @(posedge clk); #1;

        // 5: start ignored at round 5, then start in the done cycle
        do_reset();
        k_ready = 1'b1;
        begin_seq(64);
        wait_round(5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignored_start_round6", {57'h0, m_round}, 64'h6);
        wait_done(1'b0);
        end_checks(64);
        begin_seq(64);
        wait_done(1'b0);
        end_checks(64);
        @(posedge clk); #1;

        // 6: asynchronous reset between edges at round 40
        do_reset();
        k_ready = 1'b1;
        begin_seq(64);
        wait_round(40);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {63'h0, v32}, 64'h0);
        chk("arst_data", {32'h0, k32}, 64'h0);
        chk("arst_round", {57'h0, r32}, 64'h0);
        chk("arst_last", {63'h0, l32}, 64'h0);
        chk("arst_next", {32'h0, nx32}, 64'h0);
        chk("arst_busy", {63'h0, n32_busy}, 64'h0);
        flush();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_no_done", {63'h0, d32}, 64'h0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
